// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: samples rxd at bit centres using a system-clock divider,
// emits one-cycle valid / framing-error strobes and holds the last good byte.
module uart_rx_core #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_rxd_meta;
    logic            r_rxd_s;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_rx_frame_err;
    logic            r_rx_busy;
    logic            w_half_tick;
    logic            w_bit_tick;
    logic            w_sample_data;
    logic            w_cnt_clr;
    logic            w_valid_nxt;
    logic            w_ferr_nxt;
    logic            w_busy_nxt;

    assign w_half_tick = (r_cnt == CW'(HALF - 1));
    assign w_bit_tick  = (r_cnt == CW'(DIV - 1));

    // Two-flop synchronizer; idle-high reset keeps a fresh reset from seeing a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rxd_s) w_next_state = S_START;
                else          w_next_state = S_IDLE;
            end
            S_START: begin
                if (w_half_tick) w_next_state = r_rxd_s ? S_IDLE : S_DATA;
                else             w_next_state = S_START;
            end
            S_DATA: begin
                if (w_bit_tick && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
                else                                    w_next_state = S_DATA;
            end
            S_STOP: begin
                // IDLE is re-entered mid stop bit so a back-to-back start edge is caught
                if (w_bit_tick) w_next_state = r_rxd_s ? S_IDLE : S_BREAK;
                else            w_next_state = S_STOP;
            end
            S_BREAK: begin
                if (r_rxd_s) w_next_state = S_IDLE;
                else         w_next_state = S_BREAK;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output and datapath control decode
    always_comb begin
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
        w_sample_data = 1'b0;
        if ((r_state == S_STOP) && w_bit_tick) begin
            w_valid_nxt = r_rxd_s;
            w_ferr_nxt  = ~r_rxd_s;
        end else begin
            w_valid_nxt = 1'b0;
            w_ferr_nxt  = 1'b0;
        end
        if ((r_state == S_DATA) && w_bit_tick) begin
            w_sample_data = 1'b1;
        end else begin
            w_sample_data = 1'b0;
        end
        w_busy_nxt = (w_next_state != S_IDLE);
        w_cnt_clr  = (w_next_state != r_state) || w_sample_data;
    end

    // Bit-timing counter, bit index and receive shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= {CW{1'b0}};
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if ((r_state == S_IDLE) || (r_state == S_BREAK) || w_cnt_clr) begin
                r_cnt <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == S_START) begin
                r_bit_idx <= 3'd0;
            end else if (w_sample_data) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
                r_bit_idx <= r_bit_idx;
            end
            if (w_sample_data) begin
                r_shift <= {r_rxd_s, r_shift[7:1]};
            end else begin
                r_shift <= r_shift;
            end
        end
    end

    // Registered outputs; rx_data only moves on a good stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data      <= 8'h00;
            r_rx_valid     <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_rx_busy      <= 1'b0;
        end else begin
            r_rx_valid     <= w_valid_nxt;
            r_rx_frame_err <= w_ferr_nxt;
            r_rx_busy      <= w_busy_nxt;
            if (w_valid_nxt) begin
                r_rx_data <= r_shift;
            end else begin
                r_rx_data <= r_rx_data;
            end
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_frame_err;
    assign rx_busy      = r_rx_busy;

endmodule
